// File: rtl/note_voice_ctrl.sv
// Debounced note acceptance, note-to-DDS phase increment lookup, and a linear
// attack/sustain/release amplitude envelope for a single synth voice.
module note_voice_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int ATTACK_STEP   = 8,
    parameter int RELEASE_STEP  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  note_in,
    input  logic        sample_tick_in,
    output logic [31:0] phase_inc_out,
    output logic [7:0]  amp_out,
    output logic        active_out,
    output logic        note_on_out,
    output logic        note_off_out
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    state_t      state, next_state;
    logic [7:0]  note_valid;
    logic [7:0]  candidate;
    logic [7:0]  accepted;
    logic [CW-1:0] count;
    logic        accept;
    logic [8:0]  amp_sum;
    logic [8:0]  amp_diff;
    logic [7:0]  amp_up;
    logic [7:0]  amp_down;
    logic [7:0]  amp_next;

    // One octave of increments (C4..B4); the other two octaves are derived by shifting.
    function automatic logic [31:0] base_inc(input logic [3:0] idx);
        case (idx)
            4'd0:    base_inc = 32'd23409862;
            4'd1:    base_inc = 32'd24801882;
            4'd2:    base_inc = 32'd26276679;
            4'd3:    base_inc = 32'd27839171;
            4'd4:    base_inc = 32'd29494575;
            4'd5:    base_inc = 32'd31248413;
            4'd6:    base_inc = 32'd33106541;
            4'd7:    base_inc = 32'd35075158;
            4'd8:    base_inc = 32'd37160835;
            4'd9:    base_inc = 32'd39370534;
            4'd10:   base_inc = 32'd41711627;
            4'd11:   base_inc = 32'd44191930;
            default: base_inc = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] phase_lookup(input logic [7:0] n);
        logic [3:0] idx;
        if (n >= 8'd72) begin
            idx = 4'(n - 8'd72);
            phase_lookup = base_inc(idx) << 1;
        end else if (n >= 8'd60) begin
            idx = 4'(n - 8'd60);
            phase_lookup = base_inc(idx);
        end else begin
            idx = 4'(n - 8'd48);
            phase_lookup = base_inc(idx) >> 1;
        end
    endfunction

    assign note_valid = (note_in >= 8'd48 && note_in <= 8'd83) ? note_in : 8'd0;
    assign accept     = (count == CNT_MAX) && (candidate != accepted);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            candidate     <= 8'd0;
            count         <= '0;
            accepted      <= 8'd0;
            phase_inc_out <= 32'd0;
            note_on_out   <= 1'b0;
            note_off_out  <= 1'b0;
        end else begin
            note_on_out  <= 1'b0;
            note_off_out <= 1'b0;
            if (note_valid != candidate) begin
                candidate <= note_valid;
                count     <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
            if (accept) begin
                accepted <= candidate;
                if (candidate != 8'd0) begin
                    phase_inc_out <= phase_lookup(candidate);
                    note_on_out   <= 1'b1;
                end else begin
                    note_off_out  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            amp_out <= 8'd0;
        end else begin
            state   <= next_state;
            amp_out <= amp_next;
        end
    end

    assign amp_sum  = {1'b0, amp_out} + 9'(ATTACK_STEP);
    assign amp_diff = {1'b0, amp_out} - 9'(RELEASE_STEP);
    assign amp_up   = amp_sum[8] ? 8'd255 : amp_sum[7:0];
    assign amp_down = amp_diff[8] ? 8'd0 : amp_diff[7:0];

    // A tick landing on an acceptance edge is dropped; the new state owns later ticks.
    always_comb begin
        next_state = state;
        amp_next   = amp_out;
        unique case (state)
            IDLE: begin
                amp_next = 8'd0;
                if (accept && candidate != 8'd0) next_state = ATTACK;
            end
            ATTACK: begin
                if (accept && candidate == 8'd0) begin
                    next_state = RELEASE;
                end else if (!accept && sample_tick_in) begin
                    amp_next = amp_up;
                    if (amp_up == 8'd255) next_state = SUSTAIN;
                end
            end
            SUSTAIN: begin
                amp_next = 8'd255;
                if (accept && candidate == 8'd0) next_state = RELEASE;
            end
            RELEASE: begin
                if (accept && candidate != 8'd0) begin
                    next_state = ATTACK;
                end else if (!accept && sample_tick_in) begin
                    amp_next = amp_down;
                    if (amp_down == 8'd0) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        active_out = (state != IDLE);
    end

endmodule

// File: tb/tb_note_voice_ctrl.sv
// Directed bench for note_voice_ctrl: debounce latency, glitch rejection,
// phase table entries, envelope ramps, legato and asynchronous reset.
module tb_note_voice_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  note_in;
    logic        sample_tick_in;
    logic [31:0] phase_inc_out;
    logic [7:0]  amp_out;
    logic        active_out;
    logic        note_on_out;
    logic        note_off_out;

    int n_cmp = 0;
    int n_err = 0;
    int extra = 0;
    int cyc;
    int pulses;

    note_voice_ctrl #(
        .STABLE_CYCLES(4),
        .ATTACK_STEP  (8),
        .RELEASE_STEP (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .note_in       (note_in),
        .sample_tick_in(sample_tick_in),
        .phase_inc_out (phase_inc_out),
        .amp_out       (amp_out),
        .active_out    (active_out),
        .note_on_out   (note_on_out),
        .note_off_out  (note_off_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns the number of cycles until the selected pulse, or -1 on timeout.
    task automatic wait_pulse(input bit want_off, input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk_in);
            if (want_off ? note_off_out : note_on_out) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_tick();
        repeat (9) begin
            @(negedge clk_in);
            extra += note_on_out + note_off_out;
        end
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        extra += note_on_out + note_off_out;
    endtask

    initial begin
        rst_in = 1'b0;
        note_in = 8'd0;
        sample_tick_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("rst_phase", phase_inc_out, 0);
        check("rst_amp", amp_out, 0);
        check("rst_active", active_out, 0);
        check("rst_on", note_on_out, 0);
        check("rst_off", note_off_out, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        // 60/0 toggling every 2 cycles never survives the 4-cycle window
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            pulses += note_on_out + note_off_out;
            if (i % 2 == 0) note_in = (note_in == 8'd60) ? 8'd0 : 8'd60;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            pulses += note_on_out + note_off_out;
        end
        check("glitch_pulses", pulses, 0);
        check("glitch_phase", phase_inc_out, 0);
        check("glitch_active", active_out, 0);

        // clean step 0 -> 69
        note_in = 8'd69;
        wait_pulse(1'b0, 20, cyc);
        check("on_latency", cyc, 5);
        check("a4_phase", phase_inc_out, 32'd39370534);
        check("a4_active", active_out, 1);
        check("a4_no_off", note_off_out, 0);
        @(negedge clk_in);
        check("on_one_cycle", note_on_out, 0);

        // legato to C4 during ATTACK
        note_in = 8'd60;
        wait_pulse(1'b0, 20, cyc);
        check("legato_latency", cyc, 5);
        check("c4_phase", phase_inc_out, 32'd23409862);
        check("legato_no_off", note_off_out, 0);

        for (int k = 1; k <= 32; k++) begin
            do_tick();
            check($sformatf("attack_%0d", k), amp_out, (8 * k > 255) ? 255 : 8 * k);
        end
        do_tick();
        check("sustain_amp", amp_out, 255);
        check("sustain_active", active_out, 1);

        // release to zero
        note_in = 8'd0;
        wait_pulse(1'b1, 20, cyc);
        check("off_latency", cyc, 5);
        check("off_no_on", note_on_out, 0);
        check("release_start_amp", amp_out, 255);
        extra = 0;
        for (int k = 1; k <= 64; k++) begin
            do_tick();
            check($sformatf("release_%0d", k), amp_out, (255 - 4 * k < 0) ? 0 : 255 - 4 * k);
            if (k == 63) check("release_active_63", active_out, 1);
        end
        check("release_idle", active_out, 0);
        check("release_pulses", extra, 0);
        check("release_phase_kept", phase_inc_out, 32'd23409862);

        // re-trigger from RELEASE at amp 100
        note_in = 8'd60;
        wait_pulse(1'b0, 20, cyc);
        check("retrig_on", cyc, 5);
        for (int k = 0; k < 13; k++) do_tick();
        check("attack_104", amp_out, 104);
        note_in = 8'd0;
        wait_pulse(1'b1, 20, cyc);
        check("off2_latency", cyc, 5);
        do_tick();
        check("release_100", amp_out, 100);
        note_in = 8'd72;
        wait_pulse(1'b0, 20, cyc);
        check("c5_on", cyc, 5);
        check("c5_phase", phase_inc_out, 32'd46819724);
        check("c5_amp_hold", amp_out, 100);
        do_tick();
        check("reattack_108", amp_out, 108);
        note_in = 8'd48;
        wait_pulse(1'b0, 20, cyc);
        check("c3_on", cyc, 5);
        check("c3_phase", phase_inc_out, 32'd11704931);
        check("c3_amp_hold", amp_out, 108);
        do_tick();
        check("c3_attack_116", amp_out, 116);

        // asynchronous reset between edges, mid-ATTACK
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("arst_amp", amp_out, 0);
        check("arst_phase", phase_inc_out, 0);
        check("arst_active", active_out, 0);
        check("arst_on", note_on_out, 0);
        check("arst_off", note_off_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        note_in = 8'd90;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            pulses += note_on_out + note_off_out;
        end
        check("invalid_note_pulses", pulses, 0);
        check("invalid_note_active", active_out, 0);
        check("invalid_note_phase", phase_inc_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_voice_ctrl.md
Name: note_voice_ctrl

Overview:
- Sits directly downstream of the switch-to-note decoder. Consumes its 8-bit MIDI note number, where 0 means no note.
- Filters switch bounce with a stability window and produces note-on and note-off events.
- Converts the accepted note to a 32-bit DDS phase increment.
- Runs a linear attack/sustain/release amplitude envelope that feeds the oscillator and output mixer.

Parameters:
- STABLE_CYCLES, 16, consecutive clk_in cycles note_in must hold before acceptance (≥2).
- ATTACK_STEP, 8, amplitude added per sample_tick_in in ATTACK.
- RELEASE_STEP, 4, amplitude subtracted per sample_tick_in in RELEASE.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- note_in  input  8  MIDI note from the decoder; 0 = none
- sample_tick_in  input  1  one-cycle pulse at 48 kHz audio sample rate
- phase_inc_out  output  32  DDS phase increment for the current voice
- amp_out  output  8  envelope amplitude, 0..255
- active_out  output  1  high whenever state ≠ IDLE
- note_on_out  output  1  one-cycle pulse on acceptance of a new nonzero note
- note_off_out  output  1  one-cycle pulse on acceptance of note 0

Behaviour:
- Reset: one clock, clk_in. rst_in is asynchronous and active-high. It clears every register immediately: candidate=0, stable count=0, accepted note=0, state=IDLE, phase_inc_out=0, amp_out=0, active_out=0, pulses=0. Reset mid-envelope aborts with no note_off_out.
- Note validity: notes 48..83 are valid. Any other nonzero value is treated as 0.
- Stability filter:
  - When the validated note_in differs from candidate: candidate<=note_in, count<=0.
  - Otherwise count increments, saturating at STABLE_CYCLES-1.
  - Acceptance occurs on the edge where count==STABLE_CYCLES-1, candidate≠accepted. That is, STABLE_CYCLES+1 cycles after note_in changes, for a clean step.
  - A change before acceptance restarts the window. Glitches shorter than the window produce no event.
- Phase increment table:
  - Base table for notes 60..71 holds round(f·2^32/48000), with f=440·2^((n−69)/12). A4 (69) = 39370534. C4 (60) = 23409862.
  - Notes 72..83 use the base entry for n−12, shifted left 1.
  - Notes 48..59 use the base entry for n+12, shifted right 1 (truncate).
  - phase_inc_out is registered on the acceptance edge, so it is valid the cycle after. It holds its value through RELEASE and is not cleared on note-off.
- Events: note_on_out and note_off_out are registered and pulse the cycle after acceptance. Accepting a nonzero note while another nonzero note is accepted (legato) pulses note_on_out only.
- Envelope FSM (states IDLE, ATTACK, SUSTAIN, RELEASE):
  - IDLE: on accepted nonzero note → ATTACK; amp_out holds 0.
  - ATTACK: on each sample_tick_in, amp+=ATTACK_STEP, saturating at 255. On reaching 255 → SUSTAIN.
  - SUSTAIN: amp_out=255, held.
  - RELEASE: on each sample_tick_in, amp−=RELEASE_STEP, saturating at 0. On reaching 0 → IDLE.
  - Accepted note 0 in ATTACK or SUSTAIN → RELEASE from the current amp.
  - Accepted nonzero note in RELEASE → ATTACK from the current amp (no reset to 0).
  - Legato in ATTACK or SUSTAIN: state is unchanged; only phase_inc_out updates.
  - Acceptance and sample_tick_in in the same cycle: the state transition takes effect first. The tick is applied under the new state from the next tick onward, and the current tick is ignored.
  - Arithmetic uses 9-bit intermediate values, then clamps to 0..255.

Test Plan:
- STABLE_CYCLES=4, step note_in 0→69 → note_on_out pulses exactly 5 cycles after the step; phase_inc_out=39370534 on the same cycle; active_out=1.
- note_in toggles 60/0 every 2 cycles for 40 cycles → no event pulses; phase_inc_out stays 0; state stays IDLE.
- Hold note 60, ATTACK_STEP=8, tick every 10 cycles → amp_out 8,16,…,248,255 over 32 ticks, then SUSTAIN; phase_inc_out=23409862.
- From SUSTAIN, note_in→0 → note_off_out pulses once; amp_out falls by 4 per tick to 0 after 64 ticks; active_out drops; phase_inc_out retains 23409862.
- During RELEASE at amp=100, apply note 72 → note_on_out pulses; state ATTACK; amp rises from 100; phase_inc_out=46819724. Note 48 gives 11704931.
- Assert rst_in asynchronously mid-ATTACK (between edges) → all outputs 0 immediately; no pulses; after release, note_in=90 → treated as 0, no event.
